// File: rtl/cnn_pkg.sv
// ---------------------------------------------------------------------------
// cnn_pkg
//   Shared definitions for the CNN layer-2 parameter path: the sequencer state
//   encoding and the default layer-2 dimensions / datapath widths.
//   No ports (package).
// ---------------------------------------------------------------------------
package cnn_pkg;

  // Layer-2 dimensions
  localparam int L2_NUM_FILT = 4;   // output feature maps (filters)
  localparam int L2_NUM_IN   = 2;   // input feature maps per filter
  localparam int L2_ROWS     = 3;   // kernel rows per input map

  // Datapath widths
  localparam int CNN_ROW_W   = 48;  // one kernel row: 3 x 16-bit weights
  localparam int CNN_BIAS_W  = 16;
  localparam int L2_WADDR_W  = 5;
  localparam int L2_BADDR_W  = 2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    LOAD    = 3'd2,
    PRESENT = 3'd3,
    DONE    = 3'd4
  } sched_state_t;

endpackage

// File: rtl/conv2_idx_cnt.sv
// ---------------------------------------------------------------------------
// conv2_idx_cnt
//   Nested index counter for the layer-2 parameter walk. r (kernel row) is the
//   innermost digit, then f (filter), then m (input map). Clear has priority
//   over advance.
// Ports
//   clk     in   rising-edge clock
//   rst     in   asynchronous active-high reset
//   clr_i   in   synchronous clear of all three indices
//   adv_i   in   step to the next (m,f,r) position
//   f_o     out  filter index
//   m_o     out  input-map index
//   r_o     out  kernel row index
//   last_o  out  indices point at the final position of the walk
// ---------------------------------------------------------------------------
module conv2_idx_cnt #(
  parameter int NUM_FILT = 4,
  parameter int NUM_IN   = 2,
  parameter int ROWS     = 3,
  parameter int F_W      = 2,
  parameter int M_W      = 1,
  parameter int R_W      = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr_i,
  input  logic           adv_i,
  output logic [F_W-1:0] f_o,
  output logic [M_W-1:0] m_o,
  output logic [R_W-1:0] r_o,
  output logic           last_o
);

  logic [F_W-1:0] f_q, f_d;
  logic [M_W-1:0] m_q, m_d;
  logic [R_W-1:0] r_q, r_d;

  logic r_wrap, f_wrap, m_wrap;
  assign r_wrap = (r_q == R_W'(ROWS - 1));
  assign f_wrap = (f_q == F_W'(NUM_FILT - 1));
  assign m_wrap = (m_q == M_W'(NUM_IN - 1));

  always_comb begin
    r_d = r_q;
    f_d = f_q;
    m_d = m_q;
    if (clr_i) begin
      r_d = '0;
      f_d = '0;
      m_d = '0;
    end else if (adv_i) begin
      if (r_wrap) begin
        r_d = '0;
        if (f_wrap) begin
          f_d = '0;
          m_d = m_wrap ? '0 : m_q + M_W'(1);
        end else begin
          f_d = f_q + F_W'(1);
        end
      end else begin
        r_d = r_q + R_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
      f_q <= '0;
      m_q <= '0;
    end else begin
      r_q <= r_d;
      f_q <= f_d;
      m_q <= m_d;
    end
  end

  assign f_o    = f_q;
  assign m_o    = m_q;
  assign r_o    = r_q;
  assign last_o = r_wrap && f_wrap && m_wrap;

endmodule

// File: rtl/conv2_param_sched.sv
// ---------------------------------------------------------------------------
// conv2_param_sched
//   Streams layer-2 kernel rows and filter biases from the parameter memory
//   into the conv2 engine. A start pulse walks m (outer) -> f -> r (inner);
//   each step reads one weight row and one bias, then offers them on a
//   valid/ready interface tagged with (f, m, r) and a last flag.
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   start               launch pulse, only honoured in IDLE
//   abort               cancel of a running sequence (no done pulse)
//   busy                high in FETCH/LOAD/PRESENT
//   done                one-cycle pulse after the last beat is accepted
//   w_rd_en, w_addr     weight row read request
//   w_rdata             weight row, one cycle after w_rd_en
//   b_rd_en, b_addr     bias read request (same timing as weights)
//   b_rdata             bias, one cycle after b_rd_en
//   out_valid/out_ready beat handshake to the conv2 engine
//   out_filt, out_bias  kernel row and bias of the beat
//   out_f, out_m, out_r beat indices
//   out_last            final beat of the sequence
// ---------------------------------------------------------------------------
module conv2_param_sched
  import cnn_pkg::*;
#(
  parameter int NUM_FILT = L2_NUM_FILT,
  parameter int NUM_IN   = L2_NUM_IN,
  parameter int ROWS     = L2_ROWS,
  parameter int ROW_W    = CNN_ROW_W,
  parameter int BIAS_W   = CNN_BIAS_W,
  parameter int WADDR_W  = L2_WADDR_W,
  parameter int BADDR_W  = L2_BADDR_W,
  localparam int M_W     = (NUM_IN > 1) ? $clog2(NUM_IN) : 1,
  localparam int R_W     = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic               w_rd_en,
  output logic [WADDR_W-1:0] w_addr,
  input  logic [ROW_W-1:0]   w_rdata,
  output logic               b_rd_en,
  output logic [BADDR_W-1:0] b_addr,
  input  logic [BIAS_W-1:0]  b_rdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ROW_W-1:0]   out_filt,
  output logic [BIAS_W-1:0]  out_bias,
  output logic [BADDR_W-1:0] out_f,
  output logic [M_W-1:0]     out_m,
  output logic [R_W-1:0]     out_r,
  output logic               out_last
);

  sched_state_t state_q;

  logic               busy_q;
  logic               done_q;
  logic               rd_en_q;
  logic               out_valid_q;
  logic               out_last_q;
  logic [ROW_W-1:0]   out_filt_q;
  logic [BIAS_W-1:0]  out_bias_q;
  logic [BADDR_W-1:0] out_f_q;
  logic [M_W-1:0]     out_m_q;
  logic [R_W-1:0]     out_r_q;

  logic [BADDR_W-1:0] f_cnt;
  logic [M_W-1:0]     m_cnt;
  logic [R_W-1:0]     r_cnt;
  logic               cnt_last;
  logic               cnt_clr;
  logic               cnt_adv;
  logic               launch;
  logic               abort_run;
  logic               accept;

  assign launch    = (state_q == IDLE) && start && !abort;
  assign abort_run = (state_q != IDLE) && abort;
  assign accept    = (state_q == PRESENT) && out_ready && !abort;

  assign cnt_clr = launch || abort_run;
  // Counters step on acceptance of a non-final beat, so FETCH always sees the
  // indices of the beat it is about to read.
  assign cnt_adv = accept && !out_last_q;

  conv2_idx_cnt #(
    .NUM_FILT (NUM_FILT),
    .NUM_IN   (NUM_IN),
    .ROWS     (ROWS),
    .F_W      (BADDR_W),
    .M_W      (M_W),
    .R_W      (R_W)
  ) u_idx_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (cnt_clr),
    .adv_i  (cnt_adv),
    .f_o    (f_cnt),
    .m_o    (m_cnt),
    .r_o    (r_cnt),
    .last_o (cnt_last)
  );

  // Weight rows are grouped per filter: all rows of (f, m=0), then (f, m=1).
  logic [WADDR_W-1:0] w_addr_calc;
  assign w_addr_calc = WADDR_W'((32'(f_cnt) * NUM_IN + 32'(m_cnt)) * ROWS + 32'(r_cnt));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_filt_q  <= '0;
      out_bias_q  <= '0;
      out_f_q     <= '0;
      out_m_q     <= '0;
      out_r_q     <= '0;
    end else begin
      done_q  <= 1'b0;
      rd_en_q <= 1'b0;
      if (abort_run) begin
        state_q     <= IDLE;
        busy_q      <= 1'b0;
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (launch) begin
              state_q <= FETCH;
              busy_q  <= 1'b1;
              rd_en_q <= 1'b1;
            end
          end
          FETCH: begin
            state_q <= LOAD;
          end
          LOAD: begin
            out_filt_q  <= w_rdata;
            out_bias_q  <= b_rdata;
            out_f_q     <= f_cnt;
            out_m_q     <= m_cnt;
            out_r_q     <= r_cnt;
            out_last_q  <= cnt_last;
            out_valid_q <= 1'b1;
            state_q     <= PRESENT;
          end
          PRESENT: begin
            if (out_ready) begin
              out_valid_q <= 1'b0;
              if (out_last_q) begin
                state_q <= DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                state_q <= FETCH;
                rd_en_q <= 1'b1;
              end
            end
          end
          DONE: begin
            state_q <= IDLE;
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign w_rd_en   = rd_en_q;
  assign b_rd_en   = rd_en_q;
  // Addresses are driven only while a read is issued; otherwise held at zero.
  assign w_addr    = rd_en_q ? w_addr_calc : '0;
  assign b_addr    = rd_en_q ? f_cnt : '0;
  assign out_valid = out_valid_q;
  assign out_filt  = out_filt_q;
  assign out_bias  = out_bias_q;
  assign out_f     = out_f_q;
  assign out_m     = out_m_q;
  assign out_r     = out_r_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_conv2_param_sched.sv
module tb_conv2_param_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic        busy;
  logic        done;
  logic        w_rd_en;
  logic [4:0]  w_addr;
  logic [47:0] w_rdata;
  logic        b_rd_en;
  logic [1:0]  b_addr;
  logic [15:0] b_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [47:0] out_filt;
  logic [15:0] out_bias;
  logic [1:0]  out_f;
  logic [0:0]  out_m;
  logic [1:0]  out_r;
  logic        out_last;

  conv2_param_sched dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .w_rd_en   (w_rd_en),
    .w_addr    (w_addr),
    .w_rdata   (w_rdata),
    .b_rd_en   (b_rd_en),
    .b_addr    (b_addr),
    .b_rdata   (b_rdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_filt  (out_filt),
    .out_bias  (out_bias),
    .out_f     (out_f),
    .out_m     (out_m),
    .out_r     (out_r),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Parameter memory contents
  function automatic logic [47:0] wpat(int a);
    return {16'(a) ^ 16'hA5A5, 16'h1000 + 16'(a), 16'hFFFF - 16'(a)};
  endfunction
  function automatic logic [15:0] bpat(int f);
    return 16'hB000 + 16'(f) * 16'h0111;
  endfunction

  always @(posedge clk) begin
    if (w_rd_en) w_rdata <= wpat(int'(w_addr));
    if (b_rd_en) b_rdata <= bpat(int'(b_addr));
  end

  // Scoreboard
  typedef struct {
    int addr;
    int f;
    int m;
    int r;
    bit last;
  } beat_t;

  beat_t exp_q[$];
  beat_t mon_e;
  int    exp_addr[24] = '{0, 1, 2, 6, 7, 8, 12, 13, 14, 18, 19, 20,
                          3, 4, 5, 9, 10, 11, 15, 16, 17, 21, 22, 23};

  int checks = 0;
  int errors = 0;
  int accepted = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int first_valid_cyc = -1;

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(string name, logic [127:0] act);
    checks++;
    errors++;
    $display("FAIL %s actual=%0h expected=none", name, act);
  endtask

  // Monitor: compares every presented beat and every read request
  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        $display("done at cycle %0d", cyc);
      end
      if (w_rd_en) begin
        if (exp_q.size() == 0) unexpected("rd_unexpected", {w_addr, b_addr});
        else check("w_b_addr", {w_addr, b_addr}, {5'(exp_q[0].addr), 2'(exp_q[0].f)});
      end
      if (out_valid) begin
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        if (exp_q.size() == 0) begin
          unexpected("beat_unexpected", {out_f, out_m, out_r});
        end else begin
          mon_e = exp_q[0];
          check("beat", {out_filt, out_bias, out_f, out_m, out_r, out_last},
                {wpat(mon_e.addr), bpat(mon_e.f), 2'(mon_e.f), 1'(mon_e.m), 2'(mon_e.r), mon_e.last});
          if (out_ready) begin
            $display("beat %0d f=%0d m=%0d r=%0d last=%0d filt=%h bias=%h",
                     accepted, out_f, out_m, out_r, out_last, out_filt, out_bias);
            void'(exp_q.pop_front());
            accepted++;
          end
        end
      end
    end
  end

  task automatic push_seq();
    for (int k = 0; k < 24; k++) begin
      beat_t b;
      b.addr = exp_addr[k];
      b.f    = (k % 12) / 3;
      b.m    = k / 12;
      b.r    = k % 3;
      b.last = (k == 23);
      exp_q.push_back(b);
    end
  endtask

  task automatic launch(output int sc);
    push_seq();
    accepted = 0;
    first_valid_cyc = -1;
    start = 1'b1;
    sc = cyc;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_acc(int n);
    for (int i = 0; i < 400 && accepted < n; i++) begin
      @(posedge clk);
      #1;
    end
    check("acc_reached", accepted, n);
  endtask

  task automatic wait_done(int d0);
    for (int i = 0; i < 400 && done_cnt == d0; i++) begin
      @(posedge clk);
      #1;
    end
    check("done_seen", done_cnt, d0 + 1);
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 50 && !out_valid; i++) @(negedge clk);
    check("valid_seen", out_valid, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sc;
    int d0;
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ctrl", {busy, done, w_rd_en, b_rd_en, out_valid, out_last, w_addr, b_addr, out_f, out_m, out_r}, 0);
    check("reset_data", {out_filt, out_bias}, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: plain run
    d0 = done_cnt;
    launch(sc);
    wait_done(d0);
    check("first_valid_cyc", first_valid_cyc - sc, 3);
    check("done_cyc", done_cyc - sc, 73);
    check("beats_t1", accepted, 24);
    check("q_empty_t1", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    check("one_done_t1", done_cnt, d0 + 1);

    // 2: five-cycle stall on beat 4
    d0 = done_cnt;
    launch(sc);
    wait_acc(4);
    out_ready = 1'b0;
    wait_valid();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stall_valid", out_valid, 1);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_done(d0);
    check("beats_t2", accepted, 24);
    check("q_empty_t2", exp_q.size(), 0);

    // 3: abort while beat 10 is presented
    d0 = done_cnt;
    launch(sc);
    wait_acc(10);
    out_ready = 1'b0;
    wait_valid();
    @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    out_ready = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("abort_idle", {busy, out_valid, w_rd_en}, 0);
    repeat (5) @(posedge clk);
    check("abort_no_done", done_cnt, d0);

    // 3/4: restart from address 0, stray start during beat 7
    #1;
    d0 = done_cnt;
    launch(sc);
    wait_acc(7);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(d0);
    check("first_valid_t4", first_valid_cyc - sc, 3);
    check("beats_t4", accepted, 24);
    check("q_empty_t4", exp_q.size(), 0);
    repeat (4) @(posedge clk);
    check("one_done_t4", done_cnt, d0 + 1);

    // 5: asynchronous reset in the middle of LOAD of beat 1
    #1;
    d0 = done_cnt;
    launch(sc);
    wait_acc(1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("async_rst_ctrl", {busy, done, w_rd_en, b_rd_en, out_valid, out_last, w_addr, b_addr, out_f, out_m, out_r}, 0);
    check("async_rst_data", {out_filt, out_bias}, 0);
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_idle", {busy, out_valid, w_rd_en, done}, 0);
    end
    check("rst_no_done", done_cnt, d0);

    // 6: start and abort together in IDLE
    @(posedge clk);
    #1;
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("start_abort_idle", {busy, w_rd_en, out_valid}, 0);
    end
    check("start_abort_no_done", done_cnt, d0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
